pc_ras_unit: RTL and testbench

Parametrised program-counter unit with an integrated return-address stack (RAS). It is the next generation of the core's fetch-stage PC register. It adds configurable address width, a stall input, call and return modes, and overflow/underflow status. It sits at the head of the fetch stage and drives the instruction-memory address. The control unit drives `PS` and `stall` each cycle.

---
 rtl/pc_ras_unit.sv | 118 +++++++++++
 tb/tb_pc_ras_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - fetch-stage program counter with integrated return-address stack
module pc_ras_unit #(
  parameter int N = 32,
  parameter int RAS_DEPTH = 8,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N-1:0]                 in,
  input  logic [2:0]                   PS,
  input  logic                         stall,
  input  logic                         flag_clear,
  output logic [N-1:0]                 PC,
  output logic [N-1:0]                 PC4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] PS_SEQ  = 3'b001;
  localparam logic [2:0] PS_JMP  = 3'b010;
  localparam logic [2:0] PS_BRL  = 3'b011;
  localparam logic [2:0] PS_CALR = 3'b100;
  localparam logic [2:0] PS_CALA = 3'b101;
  localparam logic [2:0] PS_RET  = 3'b110;

  logic [N-1:0]  r_pc;
  logic [AW-1:0] r_top;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;
  logic [N-1:0]  r_stack [RAS_DEPTH];

  logic [N-1:0]  w_pc4;
  logic [N-1:0]  w_rel;
  logic [N-1:0]  w_pc_next;
  logic [AW-1:0] w_top_inc;
  logic [AW-1:0] w_top_dec;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_ret;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_unf_set;

  // Shifting the word offset left by two drops its top two bits, giving modulo-2^N byte offset.
  assign w_pc4     = r_pc + N'(4);
  assign w_rel     = w_pc4 + (in << 2);
  assign w_top_inc = r_top + AW'(1);
  assign w_top_dec = r_top - AW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(RAS_DEPTH));

  assign w_push    = !stall && ((PS == PS_CALR) || (PS == PS_CALA));
  assign w_ret     = !stall && (PS == PS_RET);
  assign w_pop     = w_ret && !w_empty;
  assign w_ovf_set = w_push && w_full;
  assign w_unf_set = w_ret && w_empty;

  always_comb begin
    w_pc_next = r_pc;
    if (!stall) begin
      case (PS)
        PS_SEQ:  w_pc_next = w_pc4;
        PS_JMP:  w_pc_next = in;
        PS_BRL:  w_pc_next = w_rel;
        PS_CALR: w_pc_next = w_rel;
        PS_CALA: w_pc_next = in;
        PS_RET:  w_pc_next = w_empty ? w_pc4 : r_stack[r_top];
        default: w_pc_next = r_pc;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VALUE;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_push) begin
        r_top <= w_top_inc;
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CW'(1);
      end
      // A set event in the same cycle as flag_clear leaves the flag set.
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (flag_clear) r_ovf <= 1'b0;
      if (w_unf_set)       r_unf <= 1'b1;
      else if (flag_clear) r_unf <= 1'b0;
    end
  end

  // Storage has no reset; when full, the write at top+1 lands on the oldest entry.
  always_ff @(posedge clock) begin
    if (w_push) r_stack[w_top_inc] <= w_pc4;
  end

  assign PC            = r_pc;
  assign PC4           = w_pc4;
  assign ras_count     = r_count;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb/tb_pc_ras_unit.sv - directed bench for pc_ras_unit with a queue-based reference model
module tb_pc_ras_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] tb_in = '0;
  logic [2:0]  PS = '0;
  logic        stall = 1'b0;
  logic        flag_clear = 1'b0;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [3:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  logic [31:0] m_pc = '0;
  logic [31:0] m_ras [$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  pc_ras_unit #(.N(32), .RAS_DEPTH(8), .RESET_VALUE(32'h0)) dut (
    .clock(clock), .reset(reset), .in(tb_in), .PS(PS), .stall(stall),
    .flag_clear(flag_clear), .PC(PC), .PC4(PC4), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the stack is a queue whose back is the top; pushing past 8 drops the front.
  always @(posedge clock or posedge reset) begin
    logic ovf_set;
    logic unf_set;
    logic [31:0] target;
    if (reset) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (!stall) begin
        case (PS)
          3'd1: m_pc = m_pc + 32'd4;
          3'd2: m_pc = tb_in;
          3'd3: m_pc = m_pc + 32'd4 + tb_in * 32'd4;
          3'd4, 3'd5: begin
            target = (PS == 3'd4) ? m_pc + 32'd4 + tb_in * 32'd4 : tb_in;
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 8) begin
              void'(m_ras.pop_front());
              ovf_set = 1'b1;
            end
            m_pc = target;
          end
          3'd6: begin
            if (m_ras.size() == 0) begin
              m_pc = m_pc + 32'd4;
              unf_set = 1'b1;
            end else begin
              m_pc = m_ras.pop_back();
            end
          end
          default: ;
        endcase
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (flag_clear) m_ovf = 1'b0;
      if (unf_set) m_unf = 1'b1;
      else if (flag_clear) m_unf = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("cyc_pc", PC, m_pc);
      chk("cyc_pc4", PC4, m_pc + 32'd4);
      chk("cyc_count", 32'(ras_count), 32'(m_ras.size()));
      chk("cyc_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      chk("cyc_full", 32'(ras_full), 32'(m_ras.size() == 8));
      chk("cyc_ovf", 32'(ras_overflow), 32'(m_ovf));
      chk("cyc_unf", 32'(ras_underflow), 32'(m_unf));
    end
  end

  task automatic step(input logic [2:0] ps, input logic [31:0] v, input logic st, input logic fc);
    PS = ps;
    tb_in = v;
    stall = st;
    flag_clear = fc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    started = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_pc4", PC4, 32'h4);
    chk("rst_count", 32'(ras_count), 32'd0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_ovf", 32'(ras_overflow), 32'd0);
    chk("rst_unf", 32'(ras_underflow), 32'd0);
    reset = 1'b0;

    step(3'd1, 0, 0, 0); chk("seq1", PC, 32'h4);
    step(3'd1, 0, 0, 0); chk("seq2", PC, 32'h8);
    step(3'd1, 0, 0, 0); chk("seq3", PC, 32'hC);
    step(3'd1, 0, 0, 0); chk("seq4", PC, 32'h10);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_pc4", PC4, 32'h4);
    reset = 1'b0;

    step(3'd2, 32'h100, 0, 0);
    step(3'd3, 32'hFFFF_FFFE, 0, 0); chk("brel_neg", PC, 32'hFC);
    step(3'd2, 32'hFFFF_FFFC, 0, 0);
    step(3'd1, 0, 0, 0); chk("seq_wrap", PC, 32'h0);

    step(3'd2, 32'h40, 0, 0);
    step(3'd4, 32'd3, 0, 0); chk("callr_pc", PC, 32'h50); chk("callr_cnt", 32'(ras_count), 32'd1);
    step(3'd1, 0, 0, 0); chk("after_call_seq", PC, 32'h54);
    step(3'd6, 0, 0, 0); chk("ret_pc", PC, 32'h44); chk("ret_empty", 32'(ras_empty), 32'd1);

    step(3'd2, 32'h800, 0, 0);
    for (int k = 1; k <= 9; k++) step(3'd5, 32'h1000 + 32'h100 * k, 0, 0);
    chk("ovf_full", 32'(ras_full), 32'd1);
    chk("ovf_flag", 32'(ras_overflow), 32'd1);
    chk("ovf_cnt", 32'(ras_count), 32'd8);
    for (int k = 9; k >= 2; k--) begin
      step(3'd6, 0, 0, 0);
      chk("ret_chain", PC, 32'h1000 + 32'h100 * (k - 1) + 32'h4);
    end
    chk("chain_empty", 32'(ras_empty), 32'd1);
    step(3'd0, 0, 0, 1); chk("ovf_clr", 32'(ras_overflow), 32'd0);

    step(3'd2, 32'h200, 0, 0);
    step(3'd6, 0, 0, 0); chk("unf_pc", PC, 32'h204); chk("unf_set", 32'(ras_underflow), 32'd1);
    step(3'd0, 0, 0, 1); chk("unf_clr", 32'(ras_underflow), 32'd0);
    step(3'd6, 0, 0, 1); chk("unf_pc2", PC, 32'h208); chk("unf_set_wins", 32'(ras_underflow), 32'd1);

    step(3'd2, 32'h300, 0, 0);
    step(3'd4, 32'd1, 1, 0); chk("stall_pc", PC, 32'h300); chk("stall_cnt", 32'(ras_count), 32'd0);
    step(3'd4, 32'd1, 1, 1); chk("stall_clr", 32'(ras_underflow), 32'd0);
    step(3'd6, 0, 1, 0); chk("stall_no_set", 32'(ras_underflow), 32'd0);
    step(3'd4, 32'd1, 0, 0); chk("unstall_pc", PC, 32'h308); chk("unstall_cnt", 32'(ras_count), 32'd1);
    step(3'd7, 32'hABC, 0, 0); chk("reserved_hold", PC, 32'h308);
    step(3'd6, 0, 0, 0); chk("final_ret", PC, 32'h304);
    step(3'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
